ram_arbiter_2x: RTL and testbench

Two-requester round-robin arbiter and access sequencer for the single-port 64x8 RAM. The RAM latches its address on a non-write clock edge, writes `data` to the latched address when `we=1`, and presents the latched-address word combinationally on `y`. This block turns each requester's read or write command into the correct RAM cycle sequence and returns the read data. It sits between two masters (e.g. a host loader and a processing engine) and the RAM instance.

---
 rtl/ram_arbiter_2x_if.sv | 26 ++
 rtl/ram_arbiter_2x.sv | 71 +++++++
 tb/tb_ram_arbiter_2x.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_2x_if.sv
// ram_arbiter_2x_if: two-requester command/response bus plus the single-port RAM side.
interface ram_arbiter_2x_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);
  logic                  req0, we0, gnt0, rvalid0, wdone0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  req1, we1, gnt1, rvalid1, wdone1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [DATA_WIDTH-1:0] ram_y;
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_y,
    output gnt0, rvalid0, wdone0, gnt1, rvalid1, wdone1, rdata, busy, ram_we, ram_addr, ram_data
  );
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_y,
    input  gnt0, rvalid0, wdone0, gnt1, rvalid1, wdone1, rdata, busy, ram_we, ram_addr, ram_data
  );
endinterface

// File: rtl/ram_arbiter_2x.sv
// ram_arbiter_2x: round-robin arbiter sequencing two requesters onto a single-port latched-address RAM.
module ram_arbiter_2x #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  ram_arbiter_2x_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ADDR, WR, RD} state_t;
  state_t                r_state, w_next;
  logic                  r_prio, r_owner, r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [1:0]            r_gnt, r_rvalid, r_wdone;
  logic                  w_any, w_win;
  assign w_any = bus.req0 | bus.req1;
  // on contention the pointer names the requester that did not win last
  assign w_win = (bus.req0 & bus.req1) ? r_prio : bus.req1;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = w_any ? ADDR : IDLE;
      ADDR:    w_next = r_we ? WR : RD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_prio   <= 1'b0;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_wdone  <= '0;
    end else begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_wdone  <= '0;
      if (r_state == IDLE && w_any) begin
        r_gnt[w_win] <= 1'b1;
        r_owner      <= w_win;
        r_prio       <= ~w_win;
        r_we         <= w_win ? bus.we1 : bus.we0;
        r_addr       <= w_win ? bus.addr1 : bus.addr0;
        r_wdata      <= w_win ? bus.wdata1 : bus.wdata0;
      end
      if (r_state == WR) r_wdone[r_owner] <= 1'b1;
      if (r_state == RD) begin
        r_rvalid[r_owner] <= 1'b1;
        r_rdata           <= bus.ram_y;
      end
    end
  assign bus.gnt0     = r_gnt[0];
  assign bus.gnt1     = r_gnt[1];
  assign bus.rvalid0  = r_rvalid[0];
  assign bus.rvalid1  = r_rvalid[1];
  assign bus.wdone0   = r_wdone[0];
  assign bus.wdone1   = r_wdone[1];
  assign bus.rdata    = r_rdata;
  assign bus.busy     = r_state != IDLE;
  assign bus.ram_we   = r_state == WR;
  assign bus.ram_addr = r_addr;
  assign bus.ram_data = r_wdata;
endmodule

// File: tb/tb_ram_arbiter_2x.sv
// tb_ram_arbiter_2x: directed checks of arbitration, op sequencing and reset against a behavioural 64x8 RAM.
module tb_ram_arbiter_2x;
  logic clk, rst;
  int   n_pass, n_total;
  logic [7:0] mem [64];
  logic [5:0] lat;
  logic [6:0] exp_g0, exp_g1;
  ram_arbiter_2x_if #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) bus ();
  ram_arbiter_2x #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // RAM latches address on non-write edges and writes to the latched address
  always @(posedge clk)
    if (bus.ram_we) mem[lat] <= bus.ram_data;
    else            lat <= bus.ram_addr;
  assign bus.ram_y = mem[lat];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask
  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic do_op(input logic r, input logic w, input logic [5:0] a, input logic [7:0] d,
                       input logic [7:0] exp);
    if (r) begin bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
    else   begin bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
    tick;
    chk1("gnt_win", r ? bus.gnt1 : bus.gnt0, 1'b1);
    chk1("gnt_other", r ? bus.gnt0 : bus.gnt1, 1'b0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick;
    chk1("ram_we", bus.ram_we, w);
    chk8("ram_addr", {2'b0, bus.ram_addr}, {2'b0, a});
    tick;
    if (w) chk1("wdone", r ? bus.wdone1 : bus.wdone0, 1'b1);
    else begin
      chk1("rvalid", r ? bus.rvalid1 : bus.rvalid0, 1'b1);
      chk8("rdata", bus.rdata, exp);
    end
  endtask
  initial begin
    n_pass = 0; n_total = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    lat = '0;
    rst = 1'b1;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    tick; tick;
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_gnt0", bus.gnt0, 1'b0);
    rst = 1'b0;
    bus.req0 = 1; bus.addr0 = 6'h3F; bus.req1 = 1; bus.addr1 = 6'h3F;
    tick;
    chk1("pre_rst_gnt0", bus.gnt0, 1'b1);
    chk1("pre_rst_busy", bus.busy, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk1("async_gnt0", bus.gnt0, 1'b0);
    chk1("async_busy", bus.busy, 1'b0);
    chk8("async_ram_addr", {2'b0, bus.ram_addr}, 8'h00);
    tick;
    chk1("held_gnt0", bus.gnt0, 1'b0);
    chk1("held_gnt1", bus.gnt1, 1'b0);
    chk1("held_ram_we", bus.ram_we, 1'b0);
    rst = 1'b0;
    tick;
    chk1("first_gnt0", bus.gnt0, 1'b1);
    chk1("first_gnt1", bus.gnt1, 1'b0);
    bus.req0 = 0; bus.req1 = 0;
    tick; tick;
    chk1("first_rvalid0", bus.rvalid0, 1'b1);
    chk8("first_rdata", bus.rdata, 8'h00);
    do_op(1'b0, 1'b1, 6'h3F, 8'hA5, 8'h00);
    chk1("wdone_1cyc", bus.wdone0, 1'b1);
    tick;
    chk1("wdone_drop", bus.wdone0, 1'b0);
    chk1("ram_we_drop", bus.ram_we, 1'b0);
    do_op(1'b0, 1'b0, 6'h3F, 8'h00, 8'hA5);
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 6'h00; bus.wdata0 = 8'hEE;
    tick;
    chk1("rwr_gnt0", bus.gnt0, 1'b1);
    bus.req0 = 0;
    tick;
    chk1("rwr_in_wr", bus.ram_we, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk1("rwr_we_drop", bus.ram_we, 1'b0);
    chk1("rwr_busy", bus.busy, 1'b0);
    tick;
    chk1("rwr_no_wdone", bus.wdone0, 1'b0);
    rst = 1'b0;
    do_op(1'b1, 1'b0, 6'h00, 8'h00, 8'h00);
    exp_g0 = 7'b1000001;
    exp_g1 = 7'b0001000;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 6'd5; bus.wdata0 = 8'h11;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 6'd6; bus.wdata1 = 8'h22;
    for (int c = 0; c < 7; c++) begin
      tick;
      chk1("rr_gnt0", bus.gnt0, exp_g0[c]);
      chk1("rr_gnt1", bus.gnt1, exp_g1[c]);
    end
    bus.req0 = 0; bus.req1 = 0;
    tick; tick;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 6'd5;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 6'd5; bus.wdata0 = 8'h77;
    tick;
    chk1("il_gnt1", bus.gnt1, 1'b1);
    chk1("il_gnt0", bus.gnt0, 1'b0);
    bus.req1 = 0;
    tick; tick;
    chk1("il_rvalid1", bus.rvalid1, 1'b1);
    chk1("il_rvalid0", bus.rvalid0, 1'b0);
    chk8("il_rdata", bus.rdata, 8'h11);
    tick;
    chk1("il_gnt0_next", bus.gnt0, 1'b1);
    bus.req0 = 0;
    tick; tick;
    chk1("il_wdone0", bus.wdone0, 1'b1);
    chk8("il_rdata_hold", bus.rdata, 8'h11);
    do_op(1'b0, 1'b0, 6'd6, 8'h00, 8'h22);
    do_op(1'b0, 1'b0, 6'd5, 8'h00, 8'h77);
    do_op(1'b1, 1'b1, 6'h00, 8'hFF, 8'h00);
    do_op(1'b0, 1'b1, 6'h3F, 8'h00, 8'h00);
    do_op(1'b1, 1'b0, 6'h00, 8'h00, 8'hFF);
    do_op(1'b0, 1'b0, 6'h3F, 8'h00, 8'h00);
    tick;
    chk1("end_busy", bus.busy, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
